// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator: walks the shuffled S RAM, XORs each keystream byte with
// the encrypted ROM, writes plaintext to the decrypt RAM and aborts on a non [a-z ] byte.
module rc4_prga_decrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] s_q,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       s_wren,
  input  logic [7:0] enc_q,
  output logic [4:0] enc_address,
  output logic [4:0] dec_address,
  output logic [7:0] dec_data,
  output logic       dec_wren,
  output logic       finish,
  output logic       key_valid
);

  localparam logic [4:0] LAST_K = 5'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    INC_I   = 4'd1,
    WAIT_SI = 4'd2,
    READ_SI = 4'd3,
    WAIT_SJ = 4'd4,
    READ_SJ = 4'd5,
    WR_SI   = 4'd6,
    WR_SJ   = 4'd7,
    ADDR_F  = 4'd8,
    WAIT_F  = 4'd9,
    READ_F  = 4'd10,
    WR_DEC  = 4'd11,
    CHECK   = 4'd12,
    DONE    = 4'd13
  } state_t;

  state_t     state_r;
  state_t     next_state_s;
  logic [7:0] i_r;
  logic [7:0] j_r;
  logic [7:0] si_r;
  logic [7:0] sj_r;
  logic [7:0] f_r;
  logic [7:0] ek_r;
  logic [4:0] k_r;
  logic       dec_ok_s;

  function automatic logic is_text_byte(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  assign dec_ok_s = is_text_byte(dec_data);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: one cycle per state, every read has one wait state
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = INC_I;
        end else begin
          next_state_s = IDLE;
        end
      end
      INC_I:   next_state_s = WAIT_SI;
      WAIT_SI: next_state_s = READ_SI;
      READ_SI: next_state_s = WAIT_SJ;
      WAIT_SJ: next_state_s = READ_SJ;
      READ_SJ: next_state_s = WR_SI;
      WR_SI:   next_state_s = WR_SJ;
      WR_SJ:   next_state_s = ADDR_F;
      ADDR_F:  next_state_s = WAIT_F;
      WAIT_F:  next_state_s = READ_F;
      READ_F:  next_state_s = WR_DEC;
      WR_DEC:  next_state_s = CHECK;
      CHECK: begin
        if (dec_ok_s && (k_r != LAST_K)) begin
          next_state_s = INC_I;
        end else begin
          next_state_s = DONE;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Datapath and registered outputs, updated on the edge entering each state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_r         <= 8'd0;
      j_r         <= 8'd0;
      k_r         <= 5'd0;
      si_r        <= 8'd0;
      sj_r        <= 8'd0;
      f_r         <= 8'd0;
      ek_r        <= 8'd0;
      s_address   <= 8'd0;
      s_data      <= 8'd0;
      s_wren      <= 1'b0;
      enc_address <= 5'd0;
      dec_address <= 5'd0;
      dec_data    <= 8'd0;
      dec_wren    <= 1'b0;
      finish      <= 1'b0;
      key_valid   <= 1'b0;
    end else begin
      case (next_state_s)
        IDLE: begin
          s_address   <= 8'd0;
          s_data      <= 8'd0;
          s_wren      <= 1'b0;
          enc_address <= 5'd0;
          dec_address <= 5'd0;
          dec_data    <= 8'd0;
          dec_wren    <= 1'b0;
          finish      <= 1'b0;
        end
        INC_I: begin
          if (state_r == IDLE) begin
            // fresh run: i starts at 0, so the first index is 1
            i_r       <= 8'd1;
            j_r       <= 8'd0;
            k_r       <= 5'd0;
            key_valid <= 1'b0;
            s_address <= 8'd1;
          end else begin
            i_r       <= i_r + 8'd1;
            k_r       <= k_r + 5'd1;
            s_address <= i_r + 8'd1;
          end
        end
        READ_SI: begin
          si_r      <= s_q;
          j_r       <= j_r + s_q;
          s_address <= j_r + s_q;
        end
        READ_SJ: sj_r <= s_q;
        WR_SI: begin
          s_address <= i_r;
          s_data    <= sj_r;
          s_wren    <= 1'b1;
        end
        WR_SJ: begin
          s_address <= j_r;
          s_data    <= si_r;
          s_wren    <= 1'b1;
        end
        ADDR_F: begin
          s_wren      <= 1'b0;
          s_address   <= si_r + sj_r;
          enc_address <= k_r;
        end
        READ_F: begin
          f_r  <= s_q;
          ek_r <= enc_q;
        end
        WR_DEC: begin
          dec_address <= k_r;
          dec_data    <= f_r ^ ek_r;
          dec_wren    <= 1'b1;
        end
        CHECK: dec_wren <= 1'b0;
        DONE: begin
          // DONE is reached only on an invalid byte or after the last valid one
          key_valid   <= dec_ok_s;
          finish      <= 1'b1;
          s_address   <= 8'd0;
          s_data      <= 8'd0;
          s_wren      <= 1'b0;
          enc_address <= 5'd0;
          dec_address <= 5'd0;
          dec_data    <= 8'd0;
          dec_wren    <= 1'b0;
        end
        WAIT_SI, WAIT_SJ, WAIT_F: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Scoreboard bench for rc4_prga_decrypt: a 3-byte and a 32-byte instance with RAM/ROM
// models, expectations from constants or a plain RC4 reference model.
module tb_rc4_prga_decrypt;

  logic clk = 1'b0;
  logic reset_n;
  logic start0, start1;
  logic [7:0] s_q0, s_q1, s_address0, s_address1, s_data0, s_data1;
  logic       s_wren0, s_wren1;
  logic [7:0] enc_q0, enc_q1;
  logic [4:0] enc_address0, enc_address1, dec_address0, dec_address1;
  logic [7:0] dec_data0, dec_data1;
  logic       dec_wren0, dec_wren1, finish0, finish1, key_valid0, key_valid1;

  always #5 clk = ~clk;

  rc4_prga_decrypt #(.MSG_LEN(3)) dut_short (
    .clk(clk), .reset_n(reset_n), .start(start0), .s_q(s_q0),
    .s_address(s_address0), .s_data(s_data0), .s_wren(s_wren0),
    .enc_q(enc_q0), .enc_address(enc_address0),
    .dec_address(dec_address0), .dec_data(dec_data0), .dec_wren(dec_wren0),
    .finish(finish0), .key_valid(key_valid0)
  );

  rc4_prga_decrypt #(.MSG_LEN(32)) dut_full (
    .clk(clk), .reset_n(reset_n), .start(start1), .s_q(s_q1),
    .s_address(s_address1), .s_data(s_data1), .s_wren(s_wren1),
    .enc_q(enc_q1), .enc_address(enc_address1),
    .dec_address(dec_address1), .dec_data(dec_data1), .dec_wren(dec_wren1),
    .finish(finish1), .key_valid(key_valid1)
  );

  // Memories with a registered address: q is valid two edges after the DUT drives it
  logic [7:0] sram0 [256];
  logic [7:0] sram1 [256];
  logic [7:0] rom0 [32];
  logic [7:0] rom1 [32];

  always @(posedge clk) begin
    s_q0   <= sram0[s_address0];
    enc_q0 <= rom0[enc_address0];
    if (s_wren0) sram0[s_address0] <= s_data0;
    s_q1   <= sram1[s_address1];
    enc_q1 <= rom1[enc_address1];
    if (s_wren1) sram1[s_address1] <= s_data1;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc0, start_cyc1;
  logic fin_prev0 = 1'b0, fin_prev1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues: expected dec writes {addr, data}, key_valid and finish latency
  logic [12:0] dq0[$], dq1[$];
  bit          kq0[$], kq1[$];
  int          lq0[$], lq1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic mon(input int w, input logic fin, input logic kv, input logic wr,
                     input logic [4:0] addr, input logic [7:0] data, input logic swr,
                     input logic fprev);
    logic [12:0] e;
    bit ekv;
    int elat, sc, left;
    if (wr) begin
      chk("wren_exclusive", swr, 1'b0);
      if ((w == 0 && dq0.size() == 0) || (w == 1 && dq1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dec_write inst=%0d actual=%0h required=none", w, {addr, data});
      end else begin
        if (w == 0) e = dq0.pop_front();
        else        e = dq1.pop_front();
        chk("dec_write", {addr, data}, e);
      end
    end
    if (fin) begin
      chk("finish_one_cycle", fprev, 1'b0);
      if ((w == 0 && kq0.size() == 0) || (w == 1 && kq1.size() == 0)) begin
        if (!fprev) begin
          checks++;
          errors++;
          $display("FAIL unexpected_finish inst=%0d actual=1 required=0", w);
        end
      end else begin
        if (w == 0) begin
          ekv = kq0.pop_front(); elat = lq0.pop_front(); sc = start_cyc0; left = dq0.size();
        end else begin
          ekv = kq1.pop_front(); elat = lq1.pop_front(); sc = start_cyc1; left = dq1.size();
        end
        chk("key_valid", kv, ekv);
        chk("finish_latency", cyc - sc + 1, elat);
        chk("dec_all_written", left, 0);
      end
    end
  endtask

  // Monitor: compares whatever the DUTs present, away from the active edge
  always @(negedge clk) begin
    mon(0, finish0, key_valid0, dec_wren0, dec_address0, dec_data0, s_wren0, fin_prev0);
    mon(1, finish1, key_valid1, dec_wren1, dec_address1, dec_data1, s_wren1, fin_prev1);
    fin_prev0 <= finish0;
    fin_prev1 <= finish1;
  end

  // Reference model working arrays
  logic [7:0] m_s [256];
  logic [7:0] m_enc [32];
  logic [7:0] m_dec [32];
  logic [7:0] m_ks [32];
  logic [7:0] plain [32];

  task automatic ref_prga(input int n, input bit stop_on_bad, output int done_n, output bit kv);
    int ii, jj;
    logic [7:0] t, d;
    ii = 0; jj = 0; done_n = 0; kv = 1'b1;
    for (int kk = 0; kk < n; kk++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(m_s[ii])) % 256;
      t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
      m_ks[kk] = m_s[(int'(m_s[ii]) + int'(m_s[jj])) % 256];
      d = m_ks[kk] ^ m_enc[kk];
      m_dec[kk] = d;
      done_n = kk + 1;
      if (stop_on_bad && !(d == 8'h20 || (d >= 8'h61 && d <= 8'h7A))) begin
        kv = 1'b0;
        break;
      end
    end
  endtask

  function automatic logic [7:0] rand_text();
    int r;
    r = $urandom_range(0, 26);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  task automatic push_model(input int w);
    int n_done;
    bit kv;
    for (int a = 0; a < 256; a++) m_s[a] = (w == 0) ? sram0[a] : sram1[a];
    for (int a = 0; a < 32; a++) m_enc[a] = (w == 0) ? rom0[a] : rom1[a];
    ref_prga((w == 0) ? 3 : 32, 1'b1, n_done, kv);
    for (int kk = 0; kk < n_done; kk++) begin
      if (w == 0) dq0.push_back({5'(kk), m_dec[kk]});
      else        dq1.push_back({5'(kk), m_dec[kk]});
    end
    if (w == 0) begin kq0.push_back(kv); lq0.push_back(12 * n_done + 1); end
    else        begin kq1.push_back(kv); lq1.push_back(12 * n_done + 1); end
  endtask

  task automatic drive_start(input int w);
    @(negedge clk);
    if (w == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    if (w == 0) begin start_cyc0 = cyc; start0 = 1'b0; end
    else        begin start_cyc1 = cyc; start1 = 1'b0; end
  endtask

  task automatic wait_done(input int w, input int budget);
    int n = 0;
    while (((w == 0) ? kq0.size() : kq1.size()) > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("run_complete", (w == 0) ? kq0.size() : kq1.size(), 0);
    if (w == 0) begin dq0.delete(); kq0.delete(); lq0.delete(); end
    else        begin dq1.delete(); kq1.delete(); lq1.delete(); end
  endtask

  task automatic load_identity0();
    for (int a = 0; a < 256; a++) sram0[a] = 8'(a);
  endtask

  initial begin
    logic [7:0] key_b [3];
    logic [7:0] t, expv;
    int jj, n_done;
    bit kv;

    reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    load_identity0();
    for (int a = 0; a < 256; a++) sram1[a] = 8'(a);
    for (int a = 0; a < 32; a++) begin rom0[a] = 8'h00; rom1[a] = 8'h00; end
    #12;
    chk("reset_outputs_short", {s_address0, s_data0, s_wren0, enc_address0, dec_address0,
                                dec_data0, dec_wren0, finish0, key_valid0}, 0);
    chk("reset_outputs_full", {s_address1, s_data1, s_wren1, enc_address1, dec_address1,
                               dec_data1, dec_wren1, finish1, key_valid1}, 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed valid message on identity S
    rom0[0] = 8'h63; rom0[1] = 8'h25; rom0[2] = 8'h7D;
    dq0.push_back({5'd0, 8'h61}); dq0.push_back({5'd1, 8'h20}); dq0.push_back({5'd2, 8'h7A});
    kq0.push_back(1'b1); lq0.push_back(37);
    drive_start(0);
    wait_done(0, 100);
    for (int n = 0; n < 256; n++) begin
      expv = (n == 1) ? 8'd1 : (n == 2) ? 8'd3 : (n == 3) ? 8'd5 : (n == 5) ? 8'd2 : 8'(n);
      chk("sram_after_run", sram0[n], expv);
    end

    // Directed early abort on the second byte
    load_identity0();
    rom0[0] = 8'h63; rom0[1] = 8'h05; rom0[2] = 8'h7D;
    dq0.push_back({5'd0, 8'h61}); dq0.push_back({5'd1, 8'h00});
    kq0.push_back(1'b0); lq0.push_back(25);
    drive_start(0);
    wait_done(0, 100);

    // Reset during WR_SJ of byte 1, then restart with start still held
    load_identity0();
    rom0[0] = 8'h63; rom0[1] = 8'h25; rom0[2] = 8'h7D;
    dq0.push_back({5'd0, 8'h61});
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start_cyc0 = cyc;
    repeat (18) @(negedge clk);
    chk("wr_sj_address", s_address0, 8'd3);
    chk("wr_sj_data", s_data0, 8'd2);
    chk("wr_sj_wren", s_wren0, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("reset_mid_run", {s_address0, s_data0, s_wren0, enc_address0, dec_address0,
                          dec_data0, dec_wren0, finish0, key_valid0}, 0);
    chk("byte0_written_before_reset", dq0.size(), 0);
    push_model(0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk) begin start_cyc0 = cyc; start0 = 1'b0; end
    repeat (3) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    wait_done(0, 100);

    // Random permutations, mostly-valid ciphertexts, some corrupted bytes
    for (int trial = 0; trial < 6; trial++) begin
      load_identity0();
      for (int a = 255; a > 0; a--) begin
        jj = $urandom_range(0, a);
        t = sram0[a]; sram0[a] = sram0[jj]; sram0[jj] = t;
      end
      for (int a = 0; a < 256; a++) m_s[a] = sram0[a];
      for (int a = 0; a < 32; a++) m_enc[a] = 8'h00;
      ref_prga(3, 1'b0, n_done, kv);
      for (int kk = 0; kk < 3; kk++) rom0[kk] = rand_text() ^ m_ks[kk];
      if (trial % 2 == 1) begin
        jj = $urandom_range(0, 2);
        rom0[jj] = rom0[jj] ^ 8'h80;
      end
      push_model(0);
      drive_start(0);
      wait_done(0, 100);
    end

    // Full length: S from the key schedule of key 24'h000249
    key_b[0] = 8'h00; key_b[1] = 8'h02; key_b[2] = 8'h49;
    for (int a = 0; a < 256; a++) m_s[a] = 8'(a);
    jj = 0;
    for (int a = 0; a < 256; a++) begin
      jj = (jj + int'(m_s[a]) + int'(key_b[a % 3])) % 256;
      t = m_s[a]; m_s[a] = m_s[jj]; m_s[jj] = t;
    end
    for (int a = 0; a < 256; a++) sram1[a] = m_s[a];
    for (int a = 0; a < 32; a++) m_enc[a] = 8'h00;
    ref_prga(32, 1'b0, n_done, kv);
    for (int kk = 0; kk < 32; kk++) begin
      plain[kk] = rand_text();
      rom1[kk] = plain[kk] ^ m_ks[kk];
      dq1.push_back({5'(kk), plain[kk]});
    end
    kq1.push_back(1'b1); lq1.push_back(12 * 32 + 1);
    drive_start(1);
    wait_done(1, 500);
    repeat (5) @(negedge clk);
    chk("key_valid_holds", key_valid1, 1'b1);
    push_model(1);
    drive_start(1);
    chk("key_valid_clears_on_start", key_valid1, 1'b0);
    wait_done(1, 500);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc4_prga_decrypt.md
Name: rc4_prga_decrypt

Overview:
- Second-phase RC4 engine, directly downstream of the key-scheduling shuffle stage, consuming the scrambled 256-byte S memory it leaves behind.
- Runs the pseudo-random generation algorithm over MSG_LEN encrypted bytes from the encrypted-message ROM.
- XORs each keystream byte with its ciphertext byte, writes the plaintext to the decrypted-message RAM, and checks each byte against the valid alphabet.
- Aborts early on the first invalid byte so the key-search controller can advance to the next key.

Parameters:
- MSG_LEN, 32, number of message bytes (1..32); enc_address/dec_address are 5 bits wide.

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset
- start  input  1  level; sampled only in IDLE
- s_q  input  8  S RAM read data
- s_address  output  8  S RAM address
- s_data  output  8  S RAM write data
- s_wren  output  1  S RAM write enable
- enc_q  input  8  encrypted ROM read data
- enc_address  output  5  encrypted ROM address
- dec_address  output  5  decrypted RAM address
- dec_data  output  8  decrypted RAM write data
- dec_wren  output  1  decrypted RAM write enable
- finish  output  1  one-cycle done pulse
- key_valid  output  1  result flag; meaningful from the finish cycle until the next accepted start

Behaviour:
- Reset reset_n, asynchronous, active-low; clock clk. All state on posedge clk.
- Reset state: IDLE. All outputs and internal registers i, j, k, si, sj, f, ek are 0.
- Memory timing (S RAM and ROM): an address registered on edge N is sampled as q on edge N+2, so every read uses one wait state.
- Algorithm: i=j=0. For k = 0..MSG_LEN-1:
  - i = i+1; j = j + S[i]; swap S[i] and S[j].
  - f = S[(S[i]+S[j]) mod 256]; dec[k] = f ^ enc[k].
- All index arithmetic is 8-bit mod 256; j wraps silently.
- States, one cycle each; the register updates listed happen on the edge entering the state:
  - IDLE: outputs 0 except key_valid, which holds. If start: clear i, j, k, key_valid; go INC_I.
  - INC_I: i<=i+1; s_address<=i+1.
  - WAIT_SI.
  - READ_SI: si<=s_q; j<=j+s_q; s_address<=j+s_q.
  - WAIT_SJ.
  - READ_SJ: sj<=s_q.
  - WR_SI: s_address<=i; s_data<=sj; s_wren<=1.
  - WR_SJ: s_address<=j; s_data<=si; s_wren<=1.
  - ADDR_F: s_wren<=0; s_address<=si+sj; enc_address<=k.
  - WAIT_F.
  - READ_F: f<=s_q; ek<=enc_q.
  - WR_DEC: dec_address<=k; dec_data<=f^ek; dec_wren<=1.
  - CHECK: dec_wren<=0.
    - If dec_data is in 8'h61..8'h7A or equals 8'h20: if k==MSG_LEN-1, key_valid<=1 and go DONE; else k<=k+1 and go INC_I.
    - Otherwise: key_valid<=0; go DONE.
  - DONE: finish=1 for exactly one cycle; all addresses and data returned to 0; go IDLE.
- Latency: exactly 12 cycles per byte. For an all-valid message, finish is high 12*MSG_LEN+1 cycles after the edge that sampled start.
- Invalid byte: it is still written to dec RAM before the abort. No later bytes are read or written.
- i==j: both swap writes target the same address with the same value, leaving S unchanged.
- F read after swap: the F read happens after both swap writes, so it sees post-swap contents even if si+sj equals i or j.
- start while busy: ignored. start held high through DONE: a new run begins on the cycle after DONE.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Partial S and dec RAM writes are not undone.
- s_wren and dec_wren are never high simultaneously, and are never high outside WR_SI/WR_SJ and WR_DEC respectively.

Test Plan:
- Valid message: MSG_LEN=3, S preloaded identity (S[n]=n), enc = 63,25,7D (hex).
  - Keystream must be 02,05,07; dec = 61,20,7A; key_valid=1.
  - finish pulses for exactly 1 cycle, 37 cycles after start.
- Same run, final S RAM must read S[1]=1, S[2]=3, S[3]=5, S[5]=2; all other entries identity. Byte 0 exercises the i==j swap.
- Early abort: MSG_LEN=3, identity S, enc = 63,05,7D.
  - dec[0]=61, dec[1]=00; dec[2] never written; exactly 2 dec_wren pulses.
  - key_valid=0; finish 25 cycles after start.
- Robustness:
  - Assert reset_n low during WR_SJ of byte 1: all outputs 0 immediately; no finish pulse.
  - After release with start held, the run restarts from i=j=0.
  - Pulse start again during byte 0: no effect on the sequence or timing.
- Full length: MSG_LEN=32, S from a reference KSA of key 24'h000249, enc = encryption of a 32-char lowercase/space string.
  - All 32 dec bytes match the string; key_valid=1.
  - key_valid holds until the next start is accepted, then clears.
